// File: rtl/mul_wb_merge.sv
// Writeback merge of ALU and multiplier results onto one write port.
// Losing multiply results wait in a squashable FIFO until a free cycle.
module mul_wb_merge #(
    parameter int DEPTH   = 8,
    parameter int RESERVE = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     IN_branchTaken,
    input  logic [6:0]               IN_branchSqN,
    input  logic                     IN_aluValid,
    input  logic [31:0]              IN_aluResult,
    input  logic [6:0]               IN_aluTagDst,
    input  logic [4:0]               IN_aluNmDst,
    input  logic [6:0]               IN_aluSqN,
    input  logic [2:0]               IN_aluFlags,
    input  logic                     IN_mulValid,
    input  logic [31:0]              IN_mulResult,
    input  logic [6:0]               IN_mulTagDst,
    input  logic [4:0]               IN_mulNmDst,
    input  logic [6:0]               IN_mulSqN,
    input  logic [2:0]               IN_mulFlags,
    output logic                     OUT_valid,
    output logic [31:0]              OUT_result,
    output logic [6:0]               OUT_tagDst,
    output logic [4:0]               OUT_nmDst,
    output logic [6:0]               OUT_sqN,
    output logic [2:0]               OUT_flags,
    output logic                     OUT_src,
    output logic                     OUT_busy,
    output logic [$clog2(DEPTH):0]   OUT_count,
    output logic                     OUT_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] result;
        logic [6:0]  tag;
        logic [4:0]  nm;
        logic [6:0]  sqn;
        logic [2:0]  flags;
    } res_t;

    res_t            mem_q [DEPTH];
    res_t            mem_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            out_valid_q, out_valid_d;
    logic            out_src_q, out_src_d;
    res_t            out_res_q, out_res_d;

    res_t alu_in, mul_in, head_e;
    logic alu_ok, mul_ok, empty, full;
    logic head_live, pop, bypass, push, wr;

    // Younger than the branch in 7-bit wrapping sequence space.
    function automatic logic squashed(input logic [6:0] s);
        logic [6:0] d;
        d = s - IN_branchSqN;
        return IN_branchTaken && !d[6] && (d != 7'd0);
    endfunction

    always_comb begin
        alu_in = '{IN_aluResult, IN_aluTagDst, IN_aluNmDst,
                   IN_aluSqN, IN_aluFlags};
        mul_in = '{IN_mulResult, IN_mulTagDst, IN_mulNmDst,
                   IN_mulSqN, IN_mulFlags};
        alu_ok = IN_aluValid && !squashed(IN_aluSqN);
        mul_ok = IN_mulValid && !squashed(IN_mulSqN);
        empty  = (count_q == '0);
        full   = (count_q == CW'(DEPTH));
        head_e = mem_q[head_q];
        head_live = vld_q[head_q] && !squashed(head_e.sqn);

        pop         = 1'b0;
        bypass      = 1'b0;
        out_valid_d = 1'b0;
        out_src_d   = out_src_q;
        out_res_d   = out_res_q;

        if (alu_ok) begin
            out_valid_d = 1'b1;
            out_src_d   = 1'b0;
            out_res_d   = alu_in;
            pop         = !empty && !vld_q[head_q];
        end else if (!empty) begin
            pop = 1'b1;
            if (head_live) begin
                out_valid_d = 1'b1;
                out_src_d   = 1'b1;
                out_res_d   = head_e;
            end
        end else if (mul_ok) begin
            bypass      = 1'b1;
            out_valid_d = 1'b1;
            out_src_d   = 1'b1;
            out_res_d   = mul_in;
        end

        push  = mul_ok && !bypass;
        wr    = push && !(full && !pop);
        ovf_d = ovf_q || (push && full && !pop);

        mem_d = mem_q;
        vld_d = vld_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && squashed(mem_q[i].sqn)) begin
                vld_d[i] = 1'b0;
            end
        end
        if (pop) begin
            vld_d[head_q] = 1'b0;
        end
        if (wr) begin
            vld_d[tail_q] = 1'b1;
            mem_d[tail_q] = mul_in;
        end

        head_d  = head_q + AW'(pop);
        tail_d  = tail_q + AW'(wr);
        count_d = count_q + CW'(wr) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_src_q   <= 1'b0;
            out_res_q   <= '0;
        end else begin
            vld_q       <= vld_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_src_q   <= out_src_d;
            out_res_q   <= out_res_d;
        end
    end

    // Payload needs no reset; the valid bits guard it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign OUT_valid    = out_valid_q;
    assign OUT_src      = out_src_q;
    assign OUT_result   = out_res_q.result;
    assign OUT_tagDst   = out_res_q.tag;
    assign OUT_nmDst    = out_res_q.nm;
    assign OUT_sqN      = out_res_q.sqn;
    assign OUT_flags    = out_res_q.flags;
    assign OUT_count    = count_q;
    assign OUT_overflow = ovf_q;
    assign OUT_busy     = (int'(count_q) + RESERVE) >= DEPTH;

endmodule

// File: tb/tb_mul_wb_merge.sv
// Randomized scoreboard bench for mul_wb_merge.
// A queue-based model predicts outputs; a monitor compares them.
module tb_mul_wb_merge;

    localparam int DEPTH   = 8;
    localparam int RESERVE = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br = 1'b0;
    logic [6:0]  brsq = '0;
    logic        a_v = 1'b0;
    logic [31:0] a_r = '0;
    logic [6:0]  a_t = '0;
    logic [4:0]  a_n = '0;
    logic [6:0]  a_s = '0;
    logic [2:0]  a_f = '0;
    logic        m_v = 1'b0;
    logic [31:0] m_r = '0;
    logic [6:0]  m_t = '0;
    logic [4:0]  m_n = '0;
    logic [6:0]  m_s = '0;
    logic [2:0]  m_f = '0;

    logic        o_valid, o_src, o_busy, o_ovf;
    logic [31:0] o_result;
    logic [6:0]  o_tag, o_sqn;
    logic [4:0]  o_nm;
    logic [2:0]  o_flags;
    logic [3:0]  o_count;

    mul_wb_merge #(.DEPTH(DEPTH), .RESERVE(RESERVE)) dut (
        .clk(clk), .rst(rst),
        .IN_branchTaken(br), .IN_branchSqN(brsq),
        .IN_aluValid(a_v), .IN_aluResult(a_r), .IN_aluTagDst(a_t),
        .IN_aluNmDst(a_n), .IN_aluSqN(a_s), .IN_aluFlags(a_f),
        .IN_mulValid(m_v), .IN_mulResult(m_r), .IN_mulTagDst(m_t),
        .IN_mulNmDst(m_n), .IN_mulSqN(m_s), .IN_mulFlags(m_f),
        .OUT_valid(o_valid), .OUT_result(o_result), .OUT_tagDst(o_tag),
        .OUT_nmDst(o_nm), .OUT_sqN(o_sqn), .OUT_flags(o_flags),
        .OUT_src(o_src), .OUT_busy(o_busy), .OUT_count(o_count),
        .OUT_overflow(o_ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] r;
        logic [6:0]  t;
        logic [4:0]  n;
        logic [6:0]  s;
        logic [2:0]  f;
        logic        src;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] r;
        logic [6:0]  t;
        logic [4:0]  n;
        logic [6:0]  s;
        logic [2:0]  f;
        bit          v;
    } ent_t;

    exp_t expq[$];
    ent_t mq[$];
    bit   m_ovf = 0;

    function automatic bit sq(input logic [6:0] s);
        logic signed [6:0] d;
        d = s - brsq;
        return br && (d > 0);
    endfunction

    function automatic void expect_out(input ent_t e, input logic src);
        exp_t x;
        x.r = e.r; x.t = e.t; x.n = e.n; x.s = e.s; x.f = e.f;
        x.src = src;
        x.cyc = cyc + 1;
        expq.push_back(x);
    endfunction

    function automatic void model();
        ent_t ae, me, e;
        bit alu_ok, mul_ok, hv_old, byp;
        if (rst) begin
            mq.delete();
            m_ovf = 0;
            return;
        end
        ae = '{a_r, a_t, a_n, a_s, a_f, 1'b1};
        me = '{m_r, m_t, m_n, m_s, m_f, 1'b1};
        alu_ok = a_v && !sq(a_s);
        mul_ok = m_v && !sq(m_s);
        hv_old = (mq.size() > 0) ? mq[0].v : 1'b0;
        foreach (mq[i]) if (sq(mq[i].s)) mq[i].v = 0;
        byp = 0;
        if (alu_ok) begin
            expect_out(ae, 1'b0);
            if (mq.size() > 0 && !hv_old) void'(mq.pop_front());
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            if (e.v) expect_out(e, 1'b1);
        end else if (mul_ok) begin
            expect_out(me, 1'b1);
            byp = 1;
        end
        if (mul_ok && !byp) begin
            if (mq.size() < DEPTH) mq.push_back(me);
            else m_ovf = 1;
        end
    endfunction

    task automatic step();
        int sz;
        model();
        @(posedge clk);
        #1;
        sz = mq.size();
        chk("count", 64'(o_count), 64'(sz));
        chk("busy", 64'(o_busy), 64'((sz + RESERVE) >= DEPTH));
        chk("overflow", 64'(o_ovf), 64'(m_ovf));
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (expq.size() > 0 && expq[0].cyc < cyc) begin
            e = expq.pop_front();
            nchk++;
            nerr++;
            $display("FAIL missing_out: got none expected sqn %0d (cycle %0d)",
                     e.s, e.cyc);
        end
        if (o_valid) begin
            if (expq.size() == 0 || expq[0].cyc != cyc) begin
                nchk++;
                nerr++;
                $display("FAIL unexpected_out: got sqn %0d expected none (cycle %0d)",
                         o_sqn, cyc);
            end else begin
                e = expq.pop_front();
                chk("out_fields",
                    64'({o_src, o_result, o_tag, o_nm, o_sqn, o_flags}),
                    64'({e.src, e.r, e.t, e.n, e.s, e.f}));
            end
        end
    end

    task automatic idle();
        a_v = 0; m_v = 0; br = 0; rst = 0;
    endtask

    task automatic set_alu(input logic [31:0] r, input logic [6:0] s);
        a_v = 1; a_r = r; a_t = 7'(s + 1); a_n = 5'(s); a_s = s; a_f = 3'(s);
    endtask

    task automatic set_mul(input logic [31:0] r, input logic [6:0] s,
                           input logic [6:0] t);
        m_v = 1; m_r = r; m_t = t; m_n = 5'(t); m_s = s; m_f = 3'(t);
    endtask

    initial begin
        rst = 1;
        step();
        step();
        idle();
        step();

        // bypass
        set_mul(32'h12345678, 7'd3, 7'd9);
        step();
        chk("bypass_valid", 64'(o_valid), 64'd1);
        chk("bypass_src", 64'(o_src), 64'd1);
        chk("bypass_res", 64'(o_result), 64'h12345678);
        chk("bypass_count", 64'(o_count), 64'd0);
        idle();
        step();

        // conflict
        set_alu(32'hAAAA0000, 7'd4);
        set_mul(32'h0000BBBB, 7'd5, 7'd20);
        step();
        chk("conf_alu", 64'({o_src, o_result}), 64'({1'b0, 32'hAAAA0000}));
        chk("conf_cnt1", 64'(o_count), 64'd1);
        idle();
        step();
        chk("conf_mul", 64'({o_src, o_result}), 64'({1'b1, 32'h0000BBBB}));
        chk("conf_cnt0", 64'(o_count), 64'd0);

        // busy threshold
        for (int i = 0; i < 3; i++) begin
            set_alu(32'(i), 7'(10 + i));
            set_mul(32'(100 + i), 7'(20 + i), 7'(i));
            step();
        end
        chk("busy_cnt", 64'(o_count), 64'd3);
        chk("busy_on", 64'(o_busy), 64'd1);
        idle();
        for (int i = 0; i < 3; i++) step();
        chk("busy_off", 64'(o_busy), 64'd0);
        chk("busy_drain", 64'(o_count), 64'd0);

        // squash with wrap
        set_alu(32'h1, 7'd0); set_mul(32'hC126, 7'd126, 7'd1); step();
        set_alu(32'h2, 7'd0); set_mul(32'hC012, 7'd12, 7'd2); step();
        set_alu(32'h3, 7'd0); set_mul(32'hC014, 7'd14, 7'd3); step();
        chk("sq_cnt3", 64'(o_count), 64'd3);
        idle();
        br = 1; brsq = 7'd11;
        set_mul(32'hC013, 7'd13, 7'd4);
        step();
        chk("sq_keep126", 64'({o_valid, o_sqn}), 64'({1'b1, 7'd126}));
        chk("sq_cnt2", 64'(o_count), 64'd2);
        idle();
        step();
        chk("sq_disc1", 64'(o_valid), 64'd0);
        step();
        chk("sq_disc2", 64'(o_valid), 64'd0);
        chk("sq_cnt0", 64'(o_count), 64'd0);

        // overflow
        for (int i = 0; i < 9; i++) begin
            set_alu(32'(i), 7'd50);
            set_mul(32'(200 + i), 7'(60 + i), 7'(i));
            step();
        end
        chk("ovf_flag", 64'(o_ovf), 64'd1);
        chk("ovf_cnt", 64'(o_count), 64'd8);
        idle();
        for (int i = 0; i < 8; i++) step();
        chk("ovf_sticky", 64'(o_ovf), 64'd1);

        // reset with 3 buffered entries
        for (int i = 0; i < 3; i++) begin
            set_alu(32'(i), 7'd70);
            set_mul(32'(300 + i), 7'(71 + i), 7'(i));
            step();
        end
        idle();
        rst = 1;
        step();
        rst = 0;
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_cnt", 64'(o_count), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_ovf", 64'(o_ovf), 64'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            br = ($urandom_range(0, 7) == 0);
            brsq = 7'($urandom);
            a_v = ($urandom_range(0, 99) < 55);
            a_r = $urandom; a_t = 7'($urandom); a_n = 5'($urandom);
            a_s = 7'($urandom); a_f = 3'($urandom);
            m_v = ($urandom_range(0, 1) == 1) &&
                  (!o_busy || $urandom_range(0, 15) == 0);
            m_r = $urandom; m_t = 7'($urandom); m_n = 5'($urandom);
            m_s = 7'($urandom); m_f = 3'($urandom);
            step();
        end

        idle();
        for (int i = 0; i < DEPTH + 4; i++) step();
        chk("scoreboard_empty", 64'(expq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
